// File: rtl/imem_loader.sv
// imem_loader: turns a valid/ready byte stream into little-endian 32-bit words and
// writes them to consecutive instruction-memory word addresses, one strobe per word.
module imem_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_t;

    // Largest legal load: the whole memory.
    localparam logic [CNT_W-1:0] MaxWords = CNT_W'(2 ** ADDR_W);

    state_t              state;
    logic [ADDR_W-1:0]   cur_addr;
    logic [CNT_W-1:0]    words_left;
    logic [1:0]          byte_idx;
    // Lower three lanes of the word being assembled; the top lane goes straight to wr_data.
    logic [23:0]         word;
    logic                start_ok;

    assign start_ok = (word_count != '0) && (word_count <= MaxWords);

    // Load FSM with all outputs registered alongside the state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            cur_addr   <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            word       <= '0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (start_ok) begin
                            cur_addr   <= base_addr;
                            words_left <= word_count;
                            byte_idx   <= '0;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                            state      <= StRecv;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StRecv: begin
                    if (byte_valid && byte_ready) begin
                        byte_idx <= byte_idx + 2'd1;
                        unique case (byte_idx)
                            2'd0: word[7:0]   <= byte_data;
                            2'd1: word[15:8]  <= byte_data;
                            2'd2: word[23:16] <= byte_data;
                            2'd3: begin
                                wr_addr    <= cur_addr;
                                wr_data    <= {byte_data, word};
                                wr_en      <= 1'b1;
                                byte_ready <= 1'b0;
                                state      <= StWrite;
                            end
                        endcase
                    end
                end
                StWrite: begin
                    // Address wraps naturally at the top of memory.
                    cur_addr   <= cur_addr + ADDR_W'(1);
                    words_left <= words_left - CNT_W'(1);
                    byte_idx   <= '0;
                    if (words_left == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        byte_ready <= 1'b1;
                        state      <= StRecv;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven directed loads, hand-written corner
// sequences, and randomized loads checked against an address/byte-packing model.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  base_addr;
    logic [6:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.ADDR_W(6), .CNT_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int sent = 0;

    logic [7:0]  tx_q[$];
    logic [37:0] wr_q[$];
    logic [37:0] exp_q[$];

    typedef struct packed {
        logic [5:0]        base;
        logic [6:0]        count;
        logic [1:0]        gap;
        logic [15:0][7:0]  bytes;
        logic [3:0][5:0]   exp_addr;
        logic [3:0][31:0]  exp_data;
    } vec_t;

    vec_t vecs[4];
    logic [7:0] s1[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Capture every write and check the per-cycle output relations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wr_q.push_back({wr_addr, wr_data});
                chk("ready_low_in_write", 64'(byte_ready), 64'd0);
                chk("busy_in_write", 64'(busy), 64'd1);
            end
            if (done) begin
                done_cnt++;
                chk("busy_low_in_done", 64'(busy), 64'd0);
            end
            if (err) err_cnt++;
        end
    end

    task automatic idle_cycle();
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(negedge clk);
    endtask

    // Offer a start with a garbage byte alongside; it must not be consumed in IDLE.
    task automatic do_start(input logic [5:0] b, input logic [6:0] c);
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        base_addr  = 6'($urandom);
        word_count = 7'($urandom);
        sent = 0;
    endtask

    // gap: 0 back-to-back, 1 idle cycle before every byte, 2 random idle cycles.
    task automatic send_bytes(input int n, input int gap);
        bit   acc;
        int   guard;
        logic r;
        for (int i = 0; i < n; i++) begin
            if (gap == 1) idle_cycle();
            else if (gap == 2) begin
                while ($urandom_range(0, 2) == 0) idle_cycle();
            end
            byte_valid = 1'b1;
            byte_data  = tx_q.pop_front();
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                r = byte_ready;
                @(posedge clk);
                acc = r;
                @(negedge clk);
                guard++;
                if (!acc && guard > 20) begin
                    errors++;
                    $display("FAIL byte_handshake: byte_ready stayed %0b for %0d cycles, required 1",
                             byte_ready, guard);
                    byte_valid = 1'b0;
                    return;
                end
            end
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            sent++;
            if (sent % 4 == 0) chk("write_latency", 64'(wr_en), 64'd1);
        end
    endtask

    // Entered at the negedge of the final WRITE cycle.
    task automatic finish_load(input int e0);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("no_err_in_load", 64'(err_cnt), 64'(e0));
    endtask

    task automatic run_load(input logic [5:0] b, input logic [6:0] c, input int gap);
        int e0;
        done_cnt = 0;
        e0 = err_cnt;
        do_start(b, c);
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("ready_after_start", 64'(byte_ready), 64'd1);
        send_bytes(int'(c) * 4, gap);
        finish_load(e0);
    endtask

    task automatic check_writes();
        int n;
        chk("write_count", 64'(wr_q.size()), 64'(exp_q.size()));
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("wr_addr", 64'(wr_q[i][37:32]), 64'(exp_q[i][37:32]));
            chk("wr_data", 64'(wr_q[i][31:0]), 64'(exp_q[i][31:0]));
        end
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reject(input logic [6:0] c);
        int e0;
        e0 = err_cnt;
        start      = 1'b1;
        word_count = c;
        base_addr  = 6'($urandom);
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 64'(err), 64'd1);
        chk("reject_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("err_one_cycle", 64'(err), 64'd0);
        chk("reject_idle", 64'(busy | byte_ready), 64'd0);
        chk("err_count", 64'(err_cnt), 64'(e0 + 1));
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {25'd0, byte_ready, wr_en, wr_addr, wr_data, busy, done, err}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] rb;
        int         rc;
        logic [7:0] bytes[24];

        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        byte_valid = 1'b0; byte_data = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        // Directed table.
        s1 = '{8'h03, 8'h01, 8'h10, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00};
        for (int v = 0; v < 4; v++) vecs[v] = '0;
        vecs[0].count = 7'd1;
        vecs[0].bytes[0] = 8'h83;
        vecs[0].exp_addr[0] = 6'd0;  vecs[0].exp_data[0] = 32'h00000083;
        for (int g = 1; g <= 2; g++) begin
            vecs[g].base  = 6'd1;
            vecs[g].count = 7'd2;
            vecs[g].gap   = 2'(g - 1);
            for (int i = 0; i < 8; i++) vecs[g].bytes[i] = s1[i];
            vecs[g].exp_addr[0] = 6'd1; vecs[g].exp_data[0] = 32'h00100103;
            vecs[g].exp_addr[1] = 6'd2; vecs[g].exp_data[1] = 32'h002081B3;
        end
        vecs[3].base  = 6'd62;
        vecs[3].count = 7'd4;
        for (int i = 0; i < 16; i++) vecs[3].bytes[i] = 8'(i);
        vecs[3].exp_addr = {6'd1, 6'd0, 6'd63, 6'd62};
        vecs[3].exp_data = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};

        for (int v = 0; v < 4; v++) begin
            tx_q.delete();
            for (int i = 0; i < int'(vecs[v].count) * 4; i++) tx_q.push_back(vecs[v].bytes[i]);
            for (int w = 0; w < int'(vecs[v].count); w++)
                exp_q.push_back({vecs[v].exp_addr[w], vecs[v].exp_data[w]});
            run_load(vecs[v].base, vecs[v].count, int'(vecs[v].gap));
            check_writes();
        end

        // Rejected starts.
        do_reject(7'd0);
        do_reject(7'd65);
        do_reject(7'd127);
        chk("reject_no_writes", 64'(wr_q.size()), 64'd0);

        // Start mid-load is ignored and does not disturb the load.
        begin
            int e0;
            done_cnt = 0;
            e0 = err_cnt;
            tx_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
            exp_q.push_back({6'd10, 32'hD4C3B2A1});
            do_start(6'd10, 7'd1);
            send_bytes(2, 0);
            start = 1'b1; base_addr = 6'd20; word_count = 7'd0;
            @(negedge clk);
            start = 1'b1; base_addr = 6'd30; word_count = 7'd3;
            @(negedge clk);
            start = 1'b0;
            chk("midload_no_err", 64'(err), 64'd0);
            chk("midload_busy", 64'(busy), 64'd1);
            send_bytes(2, 0);
            finish_load(e0);
            check_writes();
        end

        // Start during DONE is ignored.
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_q.push_back({6'd40, 32'h04030201});
        do_start(6'd40, 7'd1);
        send_bytes(4, 0);
        @(negedge clk);
        chk("done_before_start", 64'(done), 64'd1);
        start = 1'b1; base_addr = 6'd41; word_count = 7'd1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", 64'(busy), 64'd0);
        chk("start_in_done_no_err", 64'(err), 64'd0);
        @(negedge clk);
        chk("still_idle", 64'(busy | byte_ready), 64'd0);
        check_writes();

        // Reset in the middle of a word.
        tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_start(6'd0, 7'd2);
        send_bytes(2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_midload");
        tx_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.push_back({6'd5, 32'h44332211});
        run_load(6'd5, 7'd1, 0);
        check_writes();

        // Randomized loads against the address/byte-packing model.
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_reject(($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(65, 127)));
            end else begin
                rb = 6'($urandom_range(0, 63));
                rc = $urandom_range(1, 6);
                tx_q.delete();
                for (int i = 0; i < rc * 4; i++) begin
                    bytes[i] = 8'($urandom);
                    tx_q.push_back(bytes[i]);
                end
                for (int w = 0; w < rc; w++)
                    exp_q.push_back({6'((int'(rb) + w) % 64),
                                     bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]});
                run_load(rb, 7'(rc), $urandom_range(0, 2));
                check_writes();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
